// File: rtl/if_id_if.sv
// Fetch/decode-side bundle of the IF/ID stage: fetch inputs, ID/EX hazard
// inputs, and the pipeline register plus hazard controls driven back out.
interface if_id_if #(
    parameter int unsigned PC_W    = 64,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned CNT_W   = 16
);
    logic [PC_W-1:0]    pc_in;
    logic [INSTR_W-1:0] instr_in;
    logic               pc_src;
    logic               id_ex_mem_read;
    logic [4:0]         id_ex_rd;
    logic [PC_W-1:0]    if_id_pc;
    logic [INSTR_W-1:0] if_id_instr;
    logic               if_id_valid;
    logic               pc_write;
    logic               ctrl_bubble;
    logic [CNT_W-1:0]   stall_count;

    modport master (
        output pc_in, instr_in, pc_src, id_ex_mem_read, id_ex_rd,
        input  if_id_pc, if_id_instr, if_id_valid, pc_write, ctrl_bubble, stall_count
    );

    modport slave (
        input  pc_in, instr_in, pc_src, id_ex_mem_read, id_ex_rd,
        output if_id_pc, if_id_instr, if_id_valid, pc_write, ctrl_bubble, stall_count
    );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, branch flush,
// a one-cycle stall FSM and a saturating stall counter.
module if_id_stage #(
    parameter int unsigned PC_W    = 64,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    if_id_if.slave   bus
);

    localparam int unsigned REG_W = 5;

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PC_W-1:0]    pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [REG_W-1:0]   src1;
    logic [REG_W-1:0]   src2;
    logic               is_stur;
    logic               is_cbz;
    logic               is_b;
    logic               hazard;
    logic               stall;
    logic               pc_write;
    logic               ctrl_bubble;

    // Source-register decode of the instruction held in IF/ID
    always_comb begin
        is_stur = (instr_q[31:21] == 11'b11111000000);
        is_cbz  = (instr_q[31:24] == 8'b10110100);
        is_b    = (instr_q[31:26] == 6'b000101);
        src1    = instr_q[9:5];
        src2    = (is_stur || is_cbz) ? instr_q[4:0] : instr_q[20:16];
        hazard  = valid_q && bus.id_ex_mem_read && !is_b
                  && (bus.id_ex_rd != REG_W'(31))
                  && ((bus.id_ex_rd == src1) || (bus.id_ex_rd == src2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // A flush always lands in RUN; a stall lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (stall && !bus.pc_src) state_d = STALL;
            STALL:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Load has already advanced out of ID/EX while in STALL, so no re-detect
    always_comb begin
        stall       = 1'b0;
        pc_write    = 1'b1;
        ctrl_bubble = 1'b0;
        if (state_q == RUN) stall = hazard;
        pc_write    = !stall;
        // Decode sees no bubble request while the stage is held in reset
        ctrl_bubble = rst_n && (stall || !valid_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else if (bus.pc_src) begin
            pc_q    <= bus.pc_in;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else if (!stall) begin
            pc_q    <= bus.pc_in;
            instr_q <= bus.instr_in;
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (stall && !bus.pc_src && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.if_id_pc    = pc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_valid = valid_q;
    assign bus.pc_write    = pc_write;
    assign bus.ctrl_bubble = ctrl_bubble;
    assign bus.stall_count = cnt_q;

endmodule
